// File: rtl/std_reg_pkg.sv
// std_reg shared constants.
// Elaboration-time helpers for the flop primitive.
package std_reg_pkg;

  localparam int MIN_WIDTH = 1;

  function automatic bit width_ok(input int w);
    return w >= MIN_WIDTH;
  endfunction

endpackage

// File: rtl/std_reg_if.sv
// std_reg data bundle.
// Groups the write enable, data and stored value.
interface std_reg_if #(
  parameter int WIDTH = 1
);

  logic             wen;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (
    output wen,
    output din,
    input  dout
  );

  modport slave (
    input  wen,
    input  din,
    output dout
  );

endinterface

// File: rtl/std_reg.sv
// std_reg: enable-gated register.
// Synchronous active-high reset to RESET_VAL.
module std_reg
  import std_reg_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam logic [WIDTH-1:0] RST_V =
    WIDTH'(RESET_VAL);

  if (!width_ok(WIDTH)) begin : g_bad_w
    $error("std_reg: WIDTH must be >= 1");
  end

  if ((RESET_VAL >> WIDTH) != '0) begin : g_bad_r
    $error("std_reg: RESET_VAL wider than WIDTH");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: load din on enable, else hold.
  always_comb begin
    q_d = q_q;
    if (i_wen) q_d = i_din;
  end

  // Storage flop; reset has priority over write.
  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_V;
    else     q_q <= q_d;
  end

  assign o_dout = q_q;

endmodule

// File: tb/tb_std_reg.sv
// Self-checking bench for std_reg.
// Directed vectors at widths 1, 32 and 64.
module tb_std_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic rst_a, rst_b, rst_1, rst_w;

  std_reg_if #(.WIDTH(32)) ia ();
  std_reg_if #(.WIDTH(32)) ib ();
  std_reg_if #(.WIDTH(1))  i1 ();
  std_reg_if #(.WIDTH(64)) iw ();

  std_reg #(
    .WIDTH(32), .RESET_VAL(32'hDEAD_BEEF)
  ) dut_a (
    .clk(clk), .rst(rst_a), .i_wen(ia.wen),
    .i_din(ia.din), .o_dout(ia.dout)
  );

  std_reg #(
    .WIDTH(32), .RESET_VAL(32'h0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .i_wen(ib.wen),
    .i_din(ib.din), .o_dout(ib.dout)
  );

  std_reg #(
    .WIDTH(1), .RESET_VAL(1'b1)
  ) dut_1 (
    .clk(clk), .rst(rst_1), .i_wen(i1.wen),
    .i_din(i1.din), .o_dout(i1.dout)
  );

  std_reg #(
    .WIDTH(64), .RESET_VAL(64'h0123_4567_89AB_CDEF)
  ) dut_w (
    .clk(clk), .rst(rst_w), .i_wen(iw.wen),
    .i_din(iw.din), .o_dout(iw.dout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    ia.wen = 1'b1;
    ia.din = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ia.dout !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL reset[%0d] got=%h exp=%h",
                 i, ia.dout, 32'hDEAD_BEEF);
      end
    end
  endtask

  task automatic test_write_hold;
    rst_a = 1'b0;
    ia.wen = 1'b1;
    ia.din = 32'hA5A5_0001;
    tick();
    checks++;
    if (ia.dout !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL write got=%h exp=%h",
               ia.dout, 32'hA5A5_0001);
    end
    ia.wen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ia.din = (i == 5) ? 32'hxxxx_xxxx : 32'hFFFF_FFFF;
      tick();
      checks++;
      if (ia.dout !== 32'hA5A5_0001) begin
        failures++;
        $display("FAIL hold[%0d] got=%h exp=%h",
                 i, ia.dout, 32'hA5A5_0001);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    ia.wen = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = 32'(i);
      ia.din = exp;
      tick();
      checks++;
      if (ia.dout !== exp) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h exp=%h",
                 i, ia.dout, exp);
      end
    end
    ia.wen = 1'b0;
  endtask

  task automatic test_reset_priority;
    rst_b = 1'b0;
    ib.wen = 1'b1;
    ib.din = 32'h0000_0033;
    tick();
    checks++;
    if (ib.dout !== 32'h0000_0033) begin
      failures++;
      $display("FAIL prio_pre got=%h exp=%h",
               ib.dout, 32'h33);
    end
    rst_b = 1'b1;
    ib.din = 32'h0000_00FF;
    tick();
    checks++;
    if (ib.dout !== 32'h0) begin
      failures++;
      $display("FAIL prio_rst got=%h exp=%h",
               ib.dout, 32'h0);
    end
    rst_b = 1'b0;
    tick();
    checks++;
    if (ib.dout !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL prio_post got=%h exp=%h",
               ib.dout, 32'hFF);
    end
    ib.wen = 1'b0;
  endtask

  task automatic test_sync_only;
    ia.wen = 1'b1;
    ia.din = 32'h55;
    tick();
    checks++;
    if (ia.dout !== 32'h55) begin
      failures++;
      $display("FAIL sync_set got=%h exp=%h",
               ia.dout, 32'h55);
    end
    ia.wen = 1'b0;
    #1 rst_a = 1'b1;
    #1;
    checks++;
    if (ia.dout !== 32'h55) begin
      failures++;
      $display("FAIL sync_mid got=%h exp=%h",
               ia.dout, 32'h55);
    end
    #1 rst_a = 1'b0;
    tick();
    checks++;
    if (ia.dout !== 32'h55) begin
      failures++;
      $display("FAIL sync_after got=%h exp=%h",
               ia.dout, 32'h55);
    end
  endtask

  task automatic test_width1;
    logic [2:0] wv [4];
    logic       exp;
    rst_1 = 1'b1;
    i1.wen = 1'b1;
    i1.din = 1'b0;
    tick();
    checks++;
    if (i1.dout !== 1'b1) begin
      failures++;
      $display("FAIL w1_reset got=%b exp=1", i1.dout);
    end
    rst_1 = 1'b0;
    // {wen, din, expected}
    wv[0] = 3'b100;
    wv[1] = 3'b010;
    wv[2] = 3'b111;
    wv[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      i1.wen = wv[i][2];
      i1.din = wv[i][1];
      exp = wv[i][0];
      tick();
      checks++;
      if (i1.dout !== exp) begin
        failures++;
        $display("FAIL w1[%0d] got=%b exp=%b",
                 i, i1.dout, exp);
      end
    end
  endtask

  task automatic test_width64;
    rst_w = 1'b1;
    iw.wen = 1'b1;
    iw.din = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    checks++;
    if (iw.dout !== 64'h0123_4567_89AB_CDEF) begin
      failures++;
      $display("FAIL w64_reset got=%h exp=%h",
               iw.dout, 64'h0123_4567_89AB_CDEF);
    end
    rst_w = 1'b0;
    iw.din = 64'hFEDC_BA98_7654_3210;
    tick();
    checks++;
    if (iw.dout !== 64'hFEDC_BA98_7654_3210) begin
      failures++;
      $display("FAIL w64_write got=%h exp=%h",
               iw.dout, 64'hFEDC_BA98_7654_3210);
    end
    iw.wen = 1'b0;
    iw.din = 64'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (iw.dout !== 64'hFEDC_BA98_7654_3210) begin
        failures++;
        $display("FAIL w64_hold[%0d] got=%h exp=%h",
                 i, iw.dout, 64'hFEDC_BA98_7654_3210);
      end
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b1;
    rst_1 = 1'b0; rst_w = 1'b0;
    ia.wen = 1'b0; ia.din = '0;
    ib.wen = 1'b0; ib.din = '0;
    i1.wen = 1'b0; i1.din = '0;
    iw.wen = 1'b0; iw.din = '0;
    #1;
    test_reset();
    test_write_hold();
    test_back_to_back();
    test_reset_priority();
    test_sync_only();
    test_width1();
    test_width64();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
